// File: rtl/id_ex_reg_pkg.sv
// Pipeline types shared by the decode-to-execute register and its forwarding muxes.
package id_ex_reg_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          use_imm;
        logic [2:0]    ctrl;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          is_branch;
        logic [DW-1:0] pc;
    } id_ex_t;

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// Per-operand forwarding selector: EX/MEM beats MEM/WB beats the stored operand.
// Only built when ID_EX_FWD_EN is defined.
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] rs,
    input  logic [DW-1:0] stored,
    input  logic          fwd_ok,
    input  logic [RW-1:0] exmem_rd,
    input  logic          exmem_wr,
    input  logic [DW-1:0] exmem_data,
    input  logic [RW-1:0] memwb_rd,
    input  logic          memwb_wr,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] operand
);

    logic rs_live_s;

    // x0 is hard-wired zero, so it is never a forwarding target
    assign rs_live_s = fwd_ok & (rs != {RW{1'b0}});

    // Priority select of the operand source
    always_comb begin
        operand = stored;
        if (rs_live_s && exmem_wr && (exmem_rd == rs)) begin
            operand = exmem_data;
        end else if (rs_live_s && memwb_wr && (memwb_rd == rs)) begin
            operand = memwb_data;
        end else begin
            operand = stored;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush,
// saturating stall counter and optional operand forwarding (ID_EX_FWD_EN).
module id_ex_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic [2:0]    in_ctrl,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    input  logic          in_is_branch,
    input  logic [DW-1:0] in_pc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [2:0]    out_ctrl,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_is_branch,
    output logic [DW-1:0] out_pc,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic          exmem_wr,
    input  logic          memwb_wr,
    input  logic [DW-1:0] exmem_data,
    input  logic [DW-1:0] memwb_data,
    output logic [15:0]   stall_cnt
);

    import id_ex_reg_pkg::*;

    logic   out_valid_r;
    id_ex_t payload_r;
    id_ex_t payload_nxt_s;
    logic   accept_s;
    logic   [15:0] stall_cnt_r;

    assign in_ready = ~out_valid_r | out_ready;
    assign accept_s = in_valid & in_ready & ~flush;

    // Gather the decode-side payload; operand B is resolved to imm or rs2 data here
    always_comb begin
        payload_nxt_s           = '0;
        payload_nxt_s.rs1       = in_rs1;
        payload_nxt_s.rs2       = in_rs2;
        payload_nxt_s.a         = in_a;
        payload_nxt_s.b         = in_use_imm ? in_imm : in_b;
        payload_nxt_s.use_imm   = in_use_imm;
        payload_nxt_s.ctrl      = in_ctrl;
        payload_nxt_s.rd        = in_rd;
        payload_nxt_s.reg_write = in_reg_write;
        payload_nxt_s.is_branch = in_is_branch;
        payload_nxt_s.pc        = in_pc;
    end

    // Stage occupancy and payload: flush kills the slot but leaves payload untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            payload_r   <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            payload_r   <= payload_nxt_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of back-pressured cycles; survives flush
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_ctrl      = payload_r.ctrl;
    assign out_rd        = payload_r.rd;
    assign out_reg_write = payload_r.reg_write;
    assign out_is_branch = payload_r.is_branch;
    assign out_pc        = payload_r.pc;
    assign stall_cnt     = stall_cnt_r;

`ifdef ID_EX_FWD_EN
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .rs         (payload_r.rs1),
        .stored     (payload_r.a),
        .fwd_ok     (1'b1),
        .exmem_rd   (exmem_rd),
        .exmem_wr   (exmem_wr),
        .exmem_data (exmem_data),
        .memwb_rd   (memwb_rd),
        .memwb_wr   (memwb_wr),
        .memwb_data (memwb_data),
        .operand    (out_a)
    );

    // An immediate in B must never be overwritten by a forwarded register value
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .rs         (payload_r.rs2),
        .stored     (payload_r.b),
        .fwd_ok     (~payload_r.use_imm),
        .exmem_rd   (exmem_rd),
        .exmem_wr   (exmem_wr),
        .exmem_data (exmem_data),
        .memwb_rd   (memwb_rd),
        .memwb_wr   (memwb_wr),
        .memwb_data (memwb_data),
        .operand    (out_b)
    );
`else
    logic unused_fwd_s;

    // Without forwarding the decode hazard unit stalls instead; these inputs are dead
    assign unused_fwd_s = ^{exmem_rd, memwb_rd, exmem_wr, memwb_wr, exmem_data,
                            memwb_data, payload_r.rs1, payload_r.rs2, payload_r.use_imm};
    assign out_a = payload_r.a;
    assign out_b = payload_r.b;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (works with or without ID_EX_FWD_EN).
module tb_id_ex_reg;

    import id_ex_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_use_imm, in_reg_write, in_is_branch, flush;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, exmem_rd, memwb_rd;
    logic [31:0] in_a, in_b, in_imm, in_pc, out_a, out_b, out_pc, exmem_data, memwb_data;
    logic [2:0]  in_ctrl, out_ctrl;
    logic        out_valid, out_ready, out_reg_write, out_is_branch, exmem_wr, memwb_wr;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_is_branch(in_is_branch), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_is_branch(out_is_branch), .out_pc(out_pc),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
        .exmem_data(exmem_data), .memwb_data(memwb_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic use_imm,
                               input logic [2:0] ctrl, input logic [4:0] rd,
                               input logic [31:0] pc);
        in_rs1 = rs1; in_rs2 = rs2; in_a = a; in_b = b; in_imm = imm;
        in_use_imm = use_imm; in_ctrl = ctrl; in_rd = rd; in_pc = pc;
        in_reg_write = 1'b1; in_is_branch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive_instr(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd0, 32'd0);
        exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_wr = 1'b0; memwb_wr = 1'b0;
        exmem_data = 32'd0; memwb_data = 32'd0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0) begin n_fail++; $display("FAIL reset_ab: got %h/%h want 0/0", out_a, out_b); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        in_valid = 1'b1; out_ready = 1'b1;
        drive_instr(5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 1'b0, ALU_SUB, 5'd4, 32'h0000_0010);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_v1: got %b want 1", out_valid); end
        n_cmp++; if (out_a !== 32'd5 || out_b !== 32'd3) begin n_fail++; $display("FAIL stream_ab1: got %h/%h want 5/3", out_a, out_b); end
        n_cmp++; if (out_ctrl !== 3'b001) begin n_fail++; $display("FAIL stream_ctrl1: got %b want 001", out_ctrl); end
        drive_instr(5'd3, 5'd6, 32'h100, 32'h20, 32'd0, 1'b0, ALU_ADD, 5'd12, 32'h0000_0014);
        tick();
        n_cmp++; if (out_a !== 32'h100 || out_ctrl !== 3'b000 || out_rd !== 5'd12 || out_pc !== 32'h14) begin
            n_fail++; $display("FAIL stream_2: got a=%h ctrl=%b rd=%0d pc=%h want 100/000/12/14", out_a, out_ctrl, out_rd, out_pc); end
        drive_instr(5'd8, 5'd9, 32'hDEAD, 32'h99, 32'd7, 1'b1, 3'b111, 5'd13, 32'h0000_0018);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_b !== 32'd7 || out_ctrl !== 3'b111) begin
            n_fail++; $display("FAIL stream_3: got v=%b b=%h ctrl=%b want 1/7/111", out_valid, out_b, out_ctrl); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_a !== 32'hDEAD) begin
            n_fail++; $display("FAIL drain: got v=%b a=%h want 0/dead", out_valid, out_a); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; out_ready = 1'b0;
        drive_instr(5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, ALU_AND, 5'd9, 32'h100);
        tick();
        drive_instr(5'd1, 5'd2, 32'h30, 32'h40, 32'd0, 1'b0, ALU_OR, 5'd10, 32'h104);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        repeat (4) tick();
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd10 || out_b !== 32'd20 || out_ctrl !== 3'b011 || out_pc !== 32'h100) begin
            n_fail++; $display("FAIL stall_hold: got v=%b a=%h b=%h ctrl=%b pc=%h", out_valid, out_a, out_b, out_ctrl, out_pc); end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt4: got %0d want 4", stall_cnt); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'h30 || out_ctrl !== 3'b100 || stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL refill: got v=%b a=%h ctrl=%b cnt=%0d want 1/30/100/4", out_valid, out_a, out_ctrl, stall_cnt); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive_instr(5'd1, 5'd2, 32'h55, 32'h66, 32'd0, 1'b0, ALU_ADD, 5'd11, 32'h108);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_a !== 32'h30 || stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL flush: got v=%b a=%h cnt=%0d want 0/30/4", out_valid, out_a, stall_cnt); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %b want 0", out_valid); end
    endtask

    task automatic test_fwd();
        in_valid = 1'b1; out_ready = 1'b1;
        drive_instr(5'd7, 5'd7, 32'h11, 32'h22, 32'd0, 1'b0, ALU_ADD, 5'd3, 32'h200);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_rd = 5'd7; exmem_wr = 1'b1; exmem_data = 32'hAA;
        memwb_rd = 5'd7; memwb_wr = 1'b1; memwb_data = 32'hBB;
        #1;
        n_cmp++; if (out_a !== (FWD ? 32'hAA : 32'h11) || out_b !== (FWD ? 32'hAA : 32'h22)) begin
            n_fail++; $display("FAIL fwd_exmem: got %h/%h", out_a, out_b); end
        exmem_wr = 1'b0;
        #1;
        n_cmp++; if (out_a !== (FWD ? 32'hBB : 32'h11)) begin n_fail++; $display("FAIL fwd_memwb: got %h", out_a); end
        memwb_wr = 1'b0;
        #1;
        n_cmp++; if (out_a !== 32'h11 || out_b !== 32'h22) begin n_fail++; $display("FAIL fwd_none: got %h/%h want 11/22", out_a, out_b); end
        memwb_rd = 5'd8; memwb_wr = 1'b1;
        #1;
        n_cmp++; if (out_a !== 32'h11) begin n_fail++; $display("FAIL fwd_rd_miss: got %h want 11", out_a); end
        in_valid = 1'b1; out_ready = 1'b1;
        drive_instr(5'd0, 5'd0, 32'h33, 32'h66, 32'd0, 1'b0, ALU_ADD, 5'd3, 32'h204);
        exmem_rd = 5'd0; exmem_wr = 1'b1; memwb_rd = 5'd0; memwb_wr = 1'b1;
        tick();
        n_cmp++; if (out_a !== 32'h33 || out_b !== 32'h66) begin n_fail++; $display("FAIL fwd_x0: got %h/%h want 33/66", out_a, out_b); end
    endtask

    task automatic test_imm();
        drive_instr(5'd5, 5'd5, 32'h77, 32'h44, 32'hFFFF_FFFC, 1'b1, ALU_ADD, 5'd6, 32'h208);
        exmem_rd = 5'd5; exmem_wr = 1'b1; exmem_data = 32'hAA; memwb_wr = 1'b0;
        tick();
        n_cmp++; if (out_b !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_b: got %h want fffffffc", out_b); end
        n_cmp++; if (out_a !== (FWD ? 32'hAA : 32'h77)) begin n_fail++; $display("FAIL imm_a: got %h", out_a); end
    endtask

    task automatic test_saturate();
        in_valid = 1'b0; out_ready = 1'b0; exmem_wr = 1'b0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL saturate: got cnt=%h v=%b want ffff/1", stall_cnt, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_after_stall: got cnt=%h v=%b want 0/0", stall_cnt, out_valid); end
        n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_ctrl !== 3'b000 || out_rd !== 5'd0 ||
                     out_reg_write !== 1'b0 || out_is_branch !== 1'b0 || out_pc !== 32'd0) begin
            n_fail++; $display("FAIL rst_outputs: got a=%h b=%h ctrl=%b rd=%0d pc=%h", out_a, out_b, out_ctrl, out_rd, out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_fwd();
        test_imm();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
